master_sequencer: RTL and testbench

Parametrised instruction sequencer for the CNN accelerator: next generation of the master controller. It accepts instructions over a valid/ready handshake and keeps the layer constants. It drives neuron-read, neuron-write and kernel buffer address generators, bank selects and write strobes. A new REPEAT instruction replays the following buffer instruction N times in hardware, with automatic column/row stepping, so the host does not have to issue one instruction per word.

---
 rtl/master_seq_pkg.sv | 40 ++++
 rtl/master_sequencer_addr_gen.sv | 43 ++++
 rtl/master_sequencer.sv | 177 +++++++++++++++++
 tb/tb_master_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/master_seq_pkg.sv
// Shared opcodes, counter/bank op codes, FSM state type and instruction-width helpers
// for the master sequencer.
package master_seq_pkg;

  localparam logic [3:0] OP_LOAD_N  = 4'b0000;
  localparam logic [3:0] OP_LOAD_K  = 4'b0001;
  localparam logic [3:0] OP_LOAD_C  = 4'b0010;
  localparam logic [3:0] OP_READ_N  = 4'b0011;
  localparam logic [3:0] OP_CHG_RB  = 4'b0100;
  localparam logic [3:0] OP_CONV    = 4'b1010;
  localparam logic [3:0] OP_REPEAT  = 4'b1111;

  localparam logic [1:0] CNT_INIT = 2'b00;
  localparam logic [1:0] CNT_HOLD = 2'b01;
  localparam logic [1:0] CNT_INCR = 2'b10;
  localparam logic [1:0] CNT_JUMP = 2'b11;

  localparam logic [1:0] BNK_ZERO = 2'b00;
  localparam logic [1:0] BNK_INCR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  function automatic int f_insw(input int depth);
    return (depth > 2) ? depth : 2;
  endfunction

  function automatic int f_insd(input int depth, input int w);
    return ((1 << depth) > w) ? (1 << depth) : w;
  endfunction

  function automatic int f_inswidth(input int depth, input int w);
    return 4 + 2 + 2 * f_insw(depth) + f_insd(depth, w);
  endfunction

  // Only these opcodes can be replayed by a REPEAT burst.
  function automatic logic f_is_buf(input logic [3:0] op);
    return (op == OP_LOAD_N) || (op == OP_LOAD_K) || (op == OP_READ_N) || (op == OP_CONV);
  endfunction

endpackage

// File: rtl/master_sequencer_addr_gen.sv
// Row/column address generator: address = row*step + col, mod 2^AB.
// In auto mode the op is forced to INCR, or JUMP at the end of a row.
module seq_addr_gen import master_seq_pkg::*; #(
  parameter int AB = 11,
  parameter int AL = 7
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_auto,
  input  logic [1:0]    i_op,
  input  logic [AL-1:0] i_step,
  input  logic [AL-1:0] i_row_len,
  output logic [AB-1:0] o_addr
);

  logic [AB-1:0] r_row, r_col;
  logic [AB-1:0] w_prod;
  logic [1:0]    w_op;
  logic          w_wrap;

  // rowLen of zero means "no row length": never auto-jump.
  assign w_wrap = (i_row_len != '0) && (r_col == (AB'(i_row_len) - AB'(1)));
  assign w_op   = i_auto ? (w_wrap ? CNT_JUMP : CNT_INCR) : i_op;
  assign w_prod = r_row * AB'(i_step);
  assign o_addr = w_prod + r_col;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      unique case (w_op)
        CNT_INIT: begin r_row <= '0; r_col <= '0; end
        CNT_HOLD: ;
        CNT_INCR: r_col <= r_col + AB'(1);
        CNT_JUMP: begin r_col <= '0; r_row <= r_row + AB'(1); end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/master_sequencer.sv
// CNN accelerator instruction sequencer: decodes buffer/constant instructions and
// replays a buffer instruction in hardware after a REPEAT.
module master_sequencer import master_seq_pkg::*; #(
  parameter  int DEPTH    = 2,
  parameter  int AB       = 11,
  parameter  int AL       = 7,
  parameter  int W        = 16,
  parameter  int CW       = 8,
  localparam int INSW     = f_insw(DEPTH),
  localparam int INSD     = f_insd(DEPTH, W),
  localparam int INSWIDTH = f_inswidth(DEPTH, W)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                insValid,
  output logic                insReady,
  input  logic [INSWIDTH-1:0] instruction,
  output logic                readBufferSelect,
  output logic [AB-1:0]       nReadAddress,
  output logic [AB-1:0]       nWriteAddress,
  output logic [AB-1:0]       kBuffAddress,
  output logic                nRWrite,
  output logic                nWWrite,
  output logic                kWrite,
  output logic [DEPTH-1:0]    nBankSel,
  output logic [DEPTH-1:0]    kBankSel,
  output logic [W-1:0]        dataOut,
  output logic                busy
);

  logic [3:0]      w_in_op;
  logic [1:0]      w_in_ins1;
  logic [INSW-1:0] w_in_ins2, w_in_ins3;
  logic [INSD-1:0] w_in_last;
  logic            w_unused;

  assign {w_in_op, w_in_ins1, w_in_ins2, w_in_ins3, w_in_last} = instruction;
  assign w_unused = &{1'b0, w_in_ins3, w_in_ins2, w_in_last};

  state_t          r_state, w_state_nxt;
  logic            w_start;
  logic [CW-1:0]   r_count, r_remain;
  logic [3:0]      r_lat_op;
  logic [W-1:0]    r_lat_data;

  logic [AL-1:0]   r_n_step, r_k_step, r_w_step, r_row_len;
  logic [DEPTH-1:0] r_nbank, r_kbank;
  logic            r_rbs, r_nrw, r_nww, r_kw;
  logic [W-1:0]    r_data;

  logic            w_run, w_accept, w_exec;
  logic [3:0]      w_op;
  logic [W-1:0]    w_data;
  logic [1:0]      w_bank_op;
  logic            w_nr_en, w_nw_en, w_k_en, w_n_bank_op, w_k_bank_op;

  assign w_run     = (r_state == S_RUN);
  assign insReady  = !w_run;
  assign busy      = w_run;
  assign w_accept  = insValid && insReady;
  assign w_exec    = w_accept || w_run;
  assign w_op      = w_run ? r_lat_op : w_in_op;
  assign w_data    = w_run ? r_lat_data : w_in_last[W-1:0];
  assign w_bank_op = w_in_ins2[1:0];

  assign w_nr_en     = w_exec && ((w_op == OP_LOAD_N) || (w_op == OP_READ_N));
  assign w_nw_en     = w_exec && (w_op == OP_CONV);
  assign w_k_en      = w_exec && (w_op == OP_LOAD_K);
  // Bank selects hold during a burst; only a host-issued instruction moves them.
  assign w_n_bank_op = w_accept && ((w_in_op == OP_LOAD_N) || (w_in_op == OP_READ_N));
  assign w_k_bank_op = w_accept && (w_in_op == OP_LOAD_K);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_accept && (w_in_op == OP_REPEAT)) w_state_nxt = S_ARMED;
      S_ARMED: if (w_accept) begin
        if (w_in_op == OP_REPEAT) begin
          w_state_nxt = S_ARMED;
        end else if (f_is_buf(w_in_op) && (r_count != '0)) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN:   if (r_remain == CW'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count    <= '0;
      r_remain   <= '0;
      r_lat_op   <= '0;
      r_lat_data <= '0;
    end else begin
      if (w_accept && (w_in_op == OP_REPEAT)) r_count <= w_in_last[CW-1:0];
      if (w_start) begin
        r_remain   <= r_count;
        r_lat_op   <= w_in_op;
        r_lat_data <= w_in_last[W-1:0];
      end else if (w_run) begin
        r_remain   <= r_remain - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_n_step  <= '0;
      r_k_step  <= '0;
      r_w_step  <= '0;
      r_row_len <= '0;
      r_nbank   <= '0;
      r_kbank   <= '0;
      r_rbs     <= 1'b0;
      r_nrw     <= 1'b0;
      r_nww     <= 1'b0;
      r_kw      <= 1'b0;
      r_data    <= '0;
    end else begin
      r_nrw <= w_exec && (w_op == OP_LOAD_N);
      r_nww <= w_exec && (w_op == OP_CONV);
      r_kw  <= w_exec && (w_op == OP_LOAD_K);
      if (w_exec && f_is_buf(w_op)) r_data <= w_data;
      if (w_accept && (w_in_op == OP_LOAD_C)) begin
        unique case (w_bank_op)
          2'd0:    r_n_step  <= w_in_last[AL-1:0];
          2'd1:    r_k_step  <= w_in_last[AL-1:0];
          2'd2:    r_w_step  <= w_in_last[AL-1:0];
          default: r_row_len <= w_in_last[AL-1:0];
        endcase
      end
      if (w_accept && (w_in_op == OP_CHG_RB)) r_rbs <= !r_rbs;
      if (w_n_bank_op) begin
        if (w_bank_op == BNK_ZERO)      r_nbank <= '0;
        else if (w_bank_op == BNK_INCR) r_nbank <= r_nbank + DEPTH'(1);
      end
      if (w_k_bank_op) begin
        if (w_bank_op == BNK_ZERO)      r_kbank <= '0;
        else if (w_bank_op == BNK_INCR) r_kbank <= r_kbank + DEPTH'(1);
      end
    end
  end

  seq_addr_gen #(.AB(AB), .AL(AL)) u_nread (
    .i_clk(CLK), .i_rst_n(RST_N), .i_en(w_nr_en), .i_auto(w_run), .i_op(w_in_ins1),
    .i_step(r_n_step), .i_row_len(r_row_len), .o_addr(nReadAddress)
  );

  seq_addr_gen #(.AB(AB), .AL(AL)) u_nwrite (
    .i_clk(CLK), .i_rst_n(RST_N), .i_en(w_nw_en), .i_auto(w_run), .i_op(w_in_ins1),
    .i_step(r_w_step), .i_row_len(r_row_len), .o_addr(nWriteAddress)
  );

  seq_addr_gen #(.AB(AB), .AL(AL)) u_kernel (
    .i_clk(CLK), .i_rst_n(RST_N), .i_en(w_k_en), .i_auto(w_run), .i_op(w_in_ins1),
    .i_step(r_k_step), .i_row_len(r_row_len), .o_addr(kBuffAddress)
  );

  assign readBufferSelect = r_rbs;
  assign nRWrite          = r_nrw;
  assign nWWrite          = r_nww;
  assign kWrite           = r_kw;
  assign nBankSel         = r_nbank;
  assign kBankSel         = r_kbank;
  assign dataOut          = r_data;

endmodule

// File: tb/tb_master_sequencer.sv
// Self-checking bench for master_sequencer: directed scenarios plus random instruction
// streams compared cycle by cycle against a behavioural model.
module tb_master_sequencer;

  logic        CLK, RST_N, insValid, insReady;
  logic [25:0] instruction;
  logic        readBufferSelect, nRWrite, nWWrite, kWrite, busy;
  logic [10:0] nReadAddress, nWriteAddress, kBuffAddress;
  logic [1:0]  nBankSel, kBankSel;
  logic [15:0] dataOut;

  master_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .insValid(insValid), .insReady(insReady),
    .instruction(instruction), .readBufferSelect(readBufferSelect),
    .nReadAddress(nReadAddress), .nWriteAddress(nWriteAddress), .kBuffAddress(kBuffAddress),
    .nRWrite(nRWrite), .nWWrite(nWWrite), .kWrite(kWrite),
    .nBankSel(nBankSel), .kBankSel(kBankSel), .dataOut(dataOut), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Model state; generator index 0 = neuron read, 1 = neuron write, 2 = kernel.
  int   m_row[3], m_col[3], m_step[3];
  int   m_rowlen, m_nb, m_kb, m_rbs, m_count, m_armed, m_left, m_lat_op, m_lat_data, m_data;
  logic [2:0] m_strb;

  task automatic m_reset();
    for (int g = 0; g < 3; g++) begin m_row[g] = 0; m_col[g] = 0; m_step[g] = 0; end
    m_rowlen = 0; m_nb = 0; m_kb = 0; m_rbs = 0; m_count = 0; m_armed = 0;
    m_left = 0; m_lat_op = 0; m_lat_data = 0; m_data = 0; m_strb = 3'b000;
  endtask

  function automatic int m_addr(input int g);
    return (m_row[g] * m_step[g] + m_col[g]) % 2048;
  endfunction

  function automatic bit is_buf(input int op);
    return (op == 0) || (op == 1) || (op == 3) || (op == 10);
  endfunction

  task automatic m_exec(input int op, input int i1, input int i2, input int data, input bit auto_run);
    int g, cop;
    if (op == 2) begin
      if (i2 == 0) m_step[0] = data % 128;
      else if (i2 == 1) m_step[2] = data % 128;
      else if (i2 == 2) m_step[1] = data % 128;
      else m_rowlen = data % 128;
    end else if (op == 4) begin
      m_rbs = 1 - m_rbs;
    end else if (is_buf(op)) begin
      g = (op == 10) ? 1 : (op == 1) ? 2 : 0;
      cop = i1;
      if (auto_run) cop = (m_rowlen != 0 && m_col[g] == m_rowlen - 1) ? 3 : 2;
      if (cop == 0) begin m_row[g] = 0; m_col[g] = 0; end
      else if (cop == 2) m_col[g] = (m_col[g] + 1) % 2048;
      else if (cop == 3) begin m_col[g] = 0; m_row[g] = (m_row[g] + 1) % 2048; end
      if (!auto_run && g == 0) begin
        if (i2 == 0) m_nb = 0; else if (i2 == 2) m_nb = (m_nb + 1) % 4;
      end
      if (!auto_run && g == 2) begin
        if (i2 == 0) m_kb = 0; else if (i2 == 2) m_kb = (m_kb + 1) % 4;
      end
      if (op == 0)  m_strb[2] = 1'b1;
      if (op == 10) m_strb[1] = 1'b1;
      if (op == 1)  m_strb[0] = 1'b1;
      m_data = data;
    end
  endtask

  task automatic m_cycle(input logic v, input logic [25:0] ins);
    int op;
    op = int'(ins[25:22]);
    m_strb = 3'b000;
    if (m_left > 0) begin
      m_exec(m_lat_op, 0, 1, m_lat_data, 1'b1);
      m_left--;
    end else if (v) begin
      if (op == 15) begin
        m_count = int'(ins[7:0]);
        m_armed = 1;
      end else begin
        m_exec(op, int'(ins[21:20]), int'(ins[19:18]), int'(ins[15:0]), 1'b0);
        if (m_armed != 0) begin
          m_armed = 0;
          if (is_buf(op) && m_count > 0) begin
            m_left = m_count; m_lat_op = op; m_lat_data = int'(ins[15:0]);
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("nReadAddress",  32'(nReadAddress),  32'(m_addr(0)));
    chk("nWriteAddress", 32'(nWriteAddress), 32'(m_addr(1)));
    chk("kBuffAddress",  32'(kBuffAddress),  32'(m_addr(2)));
    chk("strobes",       32'({nRWrite, nWWrite, kWrite}), 32'(m_strb));
    chk("nBankSel",      32'(nBankSel), 32'(m_nb));
    chk("kBankSel",      32'(kBankSel), 32'(m_kb));
    chk("readBufferSelect", 32'(readBufferSelect), 32'(m_rbs));
    chk("dataOut",       32'(dataOut), 32'(m_data));
    chk("busy",          32'(busy), 32'(m_left > 0));
    chk("insReady",      32'(insReady), 32'(m_left == 0));
  endtask

  task automatic step(input logic v, input logic [25:0] ins);
    insValid = v; instruction = ins;
    @(posedge CLK); #1;
    m_cycle(v, ins);
    insValid = 1'b0;
    chk_all();
  endtask

  function automatic logic [25:0] mk(input logic [3:0] op, input logic [1:0] i1,
                                     input logic [1:0] i2, input logic [15:0] d);
    return {op, i1, i2, 2'b00, d};
  endfunction

  int kexp[7] = '{0, 1, 2, 4, 5, 6, 8};
  int bexp[5] = '{1, 2, 3, 0, 1};

  initial begin
    logic [3:0]  rop;
    logic [15:0] rdata;
    int          sel;
    RST_N = 1'b0; insValid = 1'b0; instruction = '0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    chk_all();
    chk("reset_insReady", 32'(insReady), 32'd1);

    // neuronStep=5 then INIT/INCR/JUMP
    step(1'b1, mk(4'b0010, 2'b00, 2'd0, 16'd5));
    step(1'b1, mk(4'b0000, 2'b00, 2'b01, 16'h0011));
    chk("nread_init", 32'(nReadAddress), 32'd0);
    chk("nrwrite_init", 32'(nRWrite), 32'd1);
    step(1'b1, mk(4'b0000, 2'b10, 2'b01, 16'h0022));
    chk("nread_incr", 32'(nReadAddress), 32'd1);
    step(1'b1, mk(4'b0000, 2'b11, 2'b01, 16'h0033));
    chk("nread_jump", 32'(nReadAddress), 32'd5);
    chk("nrwrite_jump", 32'(nRWrite), 32'd1);

    // Kernel burst: rowLen=3, kernelStep=4, REPEAT 6
    step(1'b1, mk(4'b0010, 2'b00, 2'd3, 16'd3));
    step(1'b1, mk(4'b0010, 2'b00, 2'd1, 16'd4));
    step(1'b1, mk(4'b1111, 2'b00, 2'b00, 16'd6));
    step(1'b1, mk(4'b0001, 2'b00, 2'b01, 16'hBEEF));
    chk("kaddr_0", 32'(kBuffAddress), 32'(kexp[0]));
    chk("kwrite_0", 32'(kWrite), 32'd1);
    chk("kbusy_0", 32'(busy), 32'd1);
    for (int i = 1; i < 7; i++) begin
      step(1'b1, mk(4'b0100, 2'b00, 2'b00, 16'd0));
      chk("kaddr_run", 32'(kBuffAddress), 32'(kexp[i]));
      chk("kwrite_run", 32'(kWrite), 32'd1);
      chk("kbusy_run", 32'(busy), 32'(i < 6));
    end
    step(1'b0, '0);
    chk("kwrite_end", 32'(kWrite), 32'd0);

    // REPEAT 0 gives a single execution; REPEAT then LOAD_CONSTANTS gives no burst
    step(1'b1, mk(4'b1111, 2'b00, 2'b00, 16'd0));
    step(1'b1, mk(4'b1010, 2'b00, 2'b00, 16'h0077));
    chk("conv_once", 32'(nWWrite), 32'd1);
    step(1'b0, '0);
    chk("conv_no_run", 32'({nWWrite, busy}), 32'd0);
    step(1'b1, mk(4'b1111, 2'b00, 2'b00, 16'd2));
    step(1'b1, mk(4'b0010, 2'b00, 2'd2, 16'd7));
    chk("loadc_no_run", 32'(busy), 32'd0);
    step(1'b0, '0);

    // Bank increments and read-buffer toggle
    step(1'b1, mk(4'b0000, 2'b01, 2'b00, 16'd0));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk(4'b0000, 2'b01, 2'b10, 16'd0));
      chk("nbank_incr", 32'(nBankSel), 32'(bexp[i]));
    end
    step(1'b1, mk(4'b0100, 2'b00, 2'b00, 16'd0));
    chk("rbs_1", 32'(readBufferSelect), 32'd1);
    step(1'b1, mk(4'b0100, 2'b00, 2'b00, 16'd0));
    chk("rbs_0", 32'(readBufferSelect), 32'd0);

    // Address wrap: writeStep=127, row 20
    step(1'b1, mk(4'b0010, 2'b00, 2'd2, 16'd127));
    step(1'b1, mk(4'b1010, 2'b00, 2'b00, 16'd0));
    for (int i = 0; i < 20; i++) step(1'b1, mk(4'b1010, 2'b11, 2'b00, 16'd0));
    chk("nwrite_wrap", 32'(nWriteAddress), 32'd492);

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: rop = 4'b0000;  1: rop = 4'b0001;  2: rop = 4'b0010;  3: rop = 4'b0011;
        4: rop = 4'b0100;  5: rop = 4'b1010;  6: rop = 4'b1111;  7: rop = 4'b1111;
        8: rop = 4'b0101;  default: rop = 4'b1100;
      endcase
      rdata = 16'($urandom);
      if (rop == 4'b1111) rdata = 16'($urandom_range(0, 6));
      if (rop == 4'b0010) rdata = 16'($urandom_range(0, 9));
      step(1'($urandom_range(0, 3) != 0),
           mk(rop, 2'($urandom), 2'($urandom), rdata));
    end

    // Reset in the middle of a count=10 burst
    for (int i = 0; i < 300 && m_left > 0; i++) step(1'b0, '0);
    step(1'b1, mk(4'b0101, 2'b00, 2'b00, 16'd0));
    step(1'b1, mk(4'b1111, 2'b00, 2'b00, 16'd10));
    step(1'b1, mk(4'b0000, 2'b00, 2'b01, 16'h0055));
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    chk("burst_active", 32'({busy, nRWrite}), 32'd3);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_strobe", 32'(nRWrite), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(insReady), 32'd1);
    chk("rst_addr", 32'(nReadAddress), 32'd0);
    m_reset();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    chk_all();
    step(1'b0, '0);
    step(1'b1, mk(4'b0000, 2'b10, 2'b10, 16'h0099));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
